// File: rtl/idma_rd_arb_pkg.sv
// Shared types and helpers for the iDMA read request arbiter.
// Order-FIFO entry layout is {owner[REQ_IDW-1:0], len[31:0]}.
package idma_rd_arb_pkg;

  localparam int unsigned LEN_WID = 32;

  typedef logic [LEN_WID-1:0] len_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_CMD  = 2'b01,
    GRANT_DROP = 2'b10
  } grant_kind_e;

  function automatic int unsigned ord_entry_wid(input int unsigned req_idw);
    return req_idw + LEN_WID;
  endfunction

endpackage

// File: rtl/idma_rd_arb_ord_fifo.sv
// Synchronous order FIFO tracking {owner, len} of each outstanding read command.
// Push is dropped when full and pop when empty; init clears pointers and count.
module idma_rd_arb_ord_fifo
  import idma_rd_arb_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned WIDTH   = 34,
  parameter int unsigned CNT_WID = 4
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               init,
  input  logic               push,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               pop,
  output logic [WIDTH-1:0]   rdata,
  output logic               full,
  output logic               empty,
  output logic [CNT_WID-1:0] count
);

  localparam int unsigned PTR_WID = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WID-1:0] PTR_LAST  = PTR_WID'(DEPTH - 1);
  localparam logic [PTR_WID-1:0] PTR_ZERO  = {PTR_WID{1'b0}};
  localparam logic [PTR_WID-1:0] PTR_ONE   = PTR_WID'(1);
  localparam logic [CNT_WID-1:0] CNT_FULL  = CNT_WID'(DEPTH);
  localparam logic [CNT_WID-1:0] CNT_ZERO  = {CNT_WID{1'b0}};
  localparam logic [CNT_WID-1:0] CNT_ONE   = CNT_WID'(1);

  logic [WIDTH-1:0]   mem_r [DEPTH];
  logic [PTR_WID-1:0] wr_ptr_r;
  logic [PTR_WID-1:0] rd_ptr_r;
  logic [CNT_WID-1:0] cnt_r;
  logic               do_push_s;
  logic               do_pop_s;

  assign full      = (cnt_r == CNT_FULL);
  assign empty     = (cnt_r == CNT_ZERO);
  assign count     = cnt_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Pointer and occupancy tracking.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      cnt_r    <= CNT_ZERO;
    end else if (init) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      cnt_r    <= CNT_ZERO;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? PTR_ZERO : wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? PTR_ZERO : rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/idma_rd_req_arb.sv
// Round-robin command arbiter and in-order data router sharing one iDMA read channel.
// Define IDMA_RD_ARB_PRIO_EN to give requester 0 absolute priority over the others.
module idma_rd_req_arb
  import idma_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned REQ_IDW          = 2,
  parameter int unsigned AXI_DATA_WID     = 128,
  parameter int unsigned AXI_ADDR_WID     = 32,
  parameter int unsigned ORD_FIFO_DEPTH   = 8,
  parameter int unsigned ORD_FIFO_CNT_WID = 4
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            rd_arb_init,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*AXI_ADDR_WID-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]           req_num,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              req_data_valid,
  output logic [AXI_DATA_WID-1:0]         req_data,
  input  logic [NUM_REQ-1:0]              req_data_ready,
  output logic [NUM_REQ-1:0]              req_done,
  output logic                            rd_req,
  output logic [AXI_ADDR_WID-1:0]         rd_addr,
  output logic [31:0]                     rd_num,
  input  logic                            rd_addr_ready,
  input  logic                            rd_data_valid,
  input  logic [AXI_DATA_WID-1:0]         rd_data,
  output logic                            rd_data_ready,
  output logic [ORD_FIFO_CNT_WID-1:0]     ord_word_cnt
);

`ifdef IDMA_RD_ARB_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  localparam int unsigned ENTRY_WID = ord_entry_wid(REQ_IDW);
  localparam int unsigned SCAN_WID  = REQ_IDW + 1;
  localparam logic [NUM_REQ-1:0]  ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [NUM_REQ-1:0]  NONE_HOT  = {NUM_REQ{1'b0}};
  localparam logic [REQ_IDW-1:0]  IDX_ZERO  = {REQ_IDW{1'b0}};
  localparam logic [REQ_IDW-1:0]  IDX_ONE   = REQ_IDW'(1);
  localparam logic [REQ_IDW-1:0]  IDX_LAST  = REQ_IDW'(NUM_REQ - 1);
  localparam logic [SCAN_WID-1:0] SCAN_MOD  = SCAN_WID'(NUM_REQ);

  logic [AXI_ADDR_WID-1:0] addr_arr_s [NUM_REQ];
  len_t                    num_arr_s  [NUM_REQ];

  logic [REQ_IDW-1:0]   rr_ptr_r;
  len_t                 beat_cnt_r;
  logic [NUM_REQ-1:0]   req_done_r;

  logic [REQ_IDW-1:0]   grant_idx_s;
  logic                 grant_any_s;
  grant_kind_e          grant_kind_s;
  len_t                 grant_num_s;
  logic                 issue_s;
  logic                 hold_ptr_s;

  logic [ENTRY_WID-1:0] head_s;
  logic [REQ_IDW-1:0]   owner_s;
  len_t                 len_s;
  logic                 ord_full_s;
  logic                 ord_empty_s;
  logic                 xfer_s;
  logic                 last_s;
  logic [NUM_REQ-1:0]   done_next_s;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr_s[i] = req_addr[i*AXI_ADDR_WID +: AXI_ADDR_WID];
    assign num_arr_s[i]  = req_num[i*LEN_WID +: LEN_WID];
  end

  // Scan upward from rr_ptr (mod NUM_REQ); in priority mode requester 0 is
  // excluded from the rotation and overrides it whenever it is valid.
  always_comb begin
    logic [SCAN_WID-1:0] raw_s;
    logic [SCAN_WID-1:0] pos_s;
    logic [REQ_IDW-1:0]  idx_s;
    logic                elig_s;
    grant_idx_s = IDX_ZERO;
    grant_any_s = 1'b0;
    raw_s       = {SCAN_WID{1'b0}};
    pos_s       = {SCAN_WID{1'b0}};
    idx_s       = IDX_ZERO;
    elig_s      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      raw_s  = {1'b0, rr_ptr_r} + SCAN_WID'(k);
      pos_s  = (raw_s >= SCAN_MOD) ? raw_s - SCAN_MOD : raw_s;
      idx_s  = REQ_IDW'(pos_s);
      elig_s = req_valid[idx_s] & ~(PRIO_EN & (idx_s == IDX_ZERO));
      if (elig_s && !grant_any_s) begin
        grant_idx_s = idx_s;
        grant_any_s = 1'b1;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    if (PRIO_EN && req_valid[0]) begin
      grant_idx_s = IDX_ZERO;
      grant_any_s = 1'b1;
    end else begin
      grant_any_s = grant_any_s;
    end
  end

  assign grant_num_s = num_arr_s[grant_idx_s];
  assign issue_s     = grant_any_s & rd_addr_ready & ~ord_full_s;
  assign hold_ptr_s  = PRIO_EN & (grant_idx_s == IDX_ZERO);

  // Zero-length commands are acknowledged but never reach the read channel.
  always_comb begin
    if (!issue_s) begin
      grant_kind_s = GRANT_NONE;
    end else if (grant_num_s == 32'd0) begin
      grant_kind_s = GRANT_DROP;
    end else begin
      grant_kind_s = GRANT_CMD;
    end
  end

  assign req_ready = (grant_kind_s != GRANT_NONE) ? (ONE_HOT_0 << grant_idx_s) : NONE_HOT;
  assign rd_req    = (grant_kind_s == GRANT_CMD);
  assign rd_addr   = rd_req ? addr_arr_s[grant_idx_s] : {AXI_ADDR_WID{1'b0}};
  assign rd_num    = rd_req ? grant_num_s : 32'd0;

  idma_rd_arb_ord_fifo #(
    .DEPTH   (ORD_FIFO_DEPTH),
    .WIDTH   (ENTRY_WID),
    .CNT_WID (ORD_FIFO_CNT_WID)
  ) u_ord_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .init    (rd_arb_init),
    .push    (rd_req),
    .wdata   ({grant_idx_s, grant_num_s}),
    .pop     (last_s),
    .rdata   (head_s),
    .full    (ord_full_s),
    .empty   (ord_empty_s),
    .count   (ord_word_cnt)
  );

  assign owner_s = head_s[ENTRY_WID-1 -: REQ_IDW];
  assign len_s   = head_s[LEN_WID-1:0];

  assign req_data       = rd_data;
  assign req_data_valid = (rd_data_valid & ~ord_empty_s) ? (ONE_HOT_0 << owner_s) : NONE_HOT;
  assign rd_data_ready  = ~ord_empty_s & req_data_ready[owner_s];
  assign xfer_s         = rd_data_valid & rd_data_ready;
  assign last_s         = xfer_s & (beat_cnt_r == len_s - 32'd1);

  assign done_next_s = (last_s ? (ONE_HOT_0 << owner_s) : NONE_HOT)
                     | ((grant_kind_s == GRANT_DROP) ? (ONE_HOT_0 << grant_idx_s) : NONE_HOT);

  // Round-robin pointer moves past each grant, except a priority requester-0 grant.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr_r <= IDX_ZERO;
    end else if (rd_arb_init) begin
      rr_ptr_r <= IDX_ZERO;
    end else if (issue_s && !hold_ptr_s) begin
      rr_ptr_r <= (grant_idx_s == IDX_LAST) ? IDX_ZERO : grant_idx_s + IDX_ONE;
    end
  end

  // Word counter for the command at the order-FIFO head.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt_r <= 32'd0;
    end else if (rd_arb_init) begin
      beat_cnt_r <= 32'd0;
    end else if (last_s) begin
      beat_cnt_r <= 32'd0;
    end else if (xfer_s) begin
      beat_cnt_r <= beat_cnt_r + 32'd1;
    end
  end

  // Done pulse, one cycle after the last word or a dropped zero-length command.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      req_done_r <= NONE_HOT;
    end else begin
      req_done_r <= done_next_s;
    end
  end

  assign req_done = req_done_r;

endmodule

// File: doc/idma_rd_req_arb.md
# idma_rd_req_arb

Round-robin request arbiter and in-order data router that shares one iDMA synchronous read channel among NUM_REQ requesters. It accepts per-requester read commands (address, word count), forwards one command per cycle to the read channel's command port, and records the owner and length of each command in an order FIFO. Returned read words are steered back to the owning requester, and a per-requester done pulse is raised on the last word. It sits between the NPU-side load engines and the read-channel top.

## Interface
- NUM_REQ, 4: number of requesters, range 2..8.
- REQ_IDW, 2: owner index width, equal to clog2(NUM_REQ).
- AXI_DATA_WID, 128: read data width.
- AXI_ADDR_WID, 32: address width.
- ORD_FIFO_DEPTH, 8: number of outstanding commands tracked.
- ORD_FIFO_CNT_WID, 4: order-FIFO count width, equal to clog2(depth)+1.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- rd_arb_init  in  1  synchronous clear of pointer, order FIFO and beat counter.
- req_valid  in  NUM_REQ  command pending, one bit per requester.
- req_addr  in  NUM_REQ*AXI_ADDR_WID  packed start addresses, requester i at slice i.
- req_num  in  NUM_REQ*32  packed word counts.
- req_ready  out  NUM_REQ  command accepted this cycle; one-hot or zero.
- req_data_valid  out  NUM_REQ  word valid for the owner; one-hot or zero.
- req_data  out  AXI_DATA_WID  broadcast read data.
- req_data_ready  in  NUM_REQ  per-requester data ready.
- req_done  out  NUM_REQ  one-cycle pulse on the owner's last word.
- rd_req  out  1  command push to the read channel.
- rd_addr  out  AXI_ADDR_WID  command address.
- rd_num  out  32  command word count.
- rd_addr_ready  in  1  read channel can accept a command.
- rd_data_valid  in  1  read channel word valid.
- rd_data  in  AXI_DATA_WID  read channel word.
- rd_data_ready  out  1  word consumed.
- ord_word_cnt  out  ORD_FIFO_CNT_WID  debug: outstanding command count.

## Operation
- Issue condition: issue = (|req_valid) & rd_addr_ready & ~ord_full.
- When issue is low, no grant is made and the round-robin pointer holds.
- Grant g is the first requester with a valid command at or after rr_ptr, scanning upward modulo NUM_REQ.
- On issue:
  - req_ready[g]=1.
  - If req_num[g]!=0: rd_req=1, rd_addr/rd_num take slice g, and {g, req_num[g]} is pushed to the order FIFO.
  - If req_num[g]==0: the command is acknowledged but dropped. rd_req stays 0, nothing is pushed, and req_done[g] pulses the next cycle.
  - In both cases rr_ptr <= g+1 (mod NUM_REQ).
- Data routing:
  - The order FIFO head gives the owner index o and the command length.
  - beat_cnt (32-bit) counts words of the head entry.
  - req_data_valid[o] = rd_data_valid & ~ord_empty.
  - rd_data_ready = req_data_ready[o] & ~ord_empty.
  - When the order FIFO is empty, rd_data_ready=0 and all req_data_valid are 0.
- A word transfers on rd_data_valid & rd_data_ready.
  - On a transfer with beat_cnt == len-1: beat_cnt <= 0, the head is popped, and req_done[o] pulses the next cycle (registered).
  - On any other transfer: beat_cnt increments.
- Simultaneous push and pop on the order FIFO are both performed; the count is unchanged. A push is blocked by full even when a pop occurs in the same cycle.
- rd_arb_init and aresetn clear rr_ptr, the order FIFO and beat_cnt. Words already in flight in the read channel are not flushed; the system must initialise the read channel's FIFOs at the same time.
- Reset values: all outputs are 0, rr_ptr=0 and ord_word_cnt=0.

## Timing
- Command path is combinational: req_valid to req_ready/rd_req takes 0 cycles, so one command can issue per cycle.
- Data path is combinational: rd_data to req_data takes 0 cycles, and rd_data_ready depends on req_data_ready in the same cycle.
- req_done lags the last data handshake by 1 cycle.
- State registers are rr_ptr, the order FIFO and beat_cnt.
- A requester must hold req_valid, req_addr and req_num stable until req_ready.

## Configuration
- IDMA_RD_ARB_PRIO_EN defined: requester 0 has absolute priority. It is granted whenever req_valid[0]=1, and rr_ptr is unchanged on a requester-0 grant. Requesters 1..NUM_REQ-1 rotate round-robin among themselves.
- IDMA_RD_ARB_PRIO_EN undefined: pure round-robin over all requesters.

## Structure
- Shared package idma_rd_arb_pkg holds:
  - the order-entry layout {owner[REQ_IDW-1:0], len[31:0]};
  - the entry width REQ_IDW+32.
- The natural sub-module is idma_rd_arb_ord_fifo, a synchronous FIFO with push, pop, full, empty, init and count.
- The round-robin grant logic stays in the top module.

## Test plan
- Reset with all inputs idle: all outputs 0 and ord_word_cnt=0. A pulse on rd_arb_init mid-transfer returns ord_word_cnt to 0 and beat_cnt to 0.
- Single command:
  - Stimulus: req_valid=4'b0100, addr=0x1000, num=3.
  - Required: rd_req with addr 0x1000 and num 3 in the same cycle; 3 words on req_data_valid[2]; req_done[2] one cycle after the 3rd word.
- Round-robin fairness:
  - Stimulus: all four requesters valid continuously, each with num=1.
  - Required: grants 0,1,2,3,0,…
  - Required: data returns in grant order and each req_done fires exactly once per command.
- Backpressure:
  - Stimulus: rd_addr_ready=0 for 5 cycles.
  - Required: no req_ready or rd_req during those cycles.
  - Stimulus: fill 8 outstanding commands with no data returned.
  - Required: the 9th command is held until the first entry's last word pops it.
- Zero-length command and owner stall:
  - Stimulus: num=0 on requester 1.
  - Required: req_ready[1] and then req_done[1] pulse; no rd_req.
  - Stimulus: owner drops req_data_ready mid-command.
  - Required: rd_data_ready=0 and beat_cnt holds.
- IDMA_RD_ARB_PRIO_EN:
  - Stimulus: requesters 0 and 3 both continuously valid.
  - Required: with the macro defined, only requester 0 is granted until it deasserts; without the macro, grants alternate between 0 and 3.
